div_seq: RTL and testbench

//  Parametrised multicycle restoring divider for the CPU datapath (DIV/DIVU).

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 38 +++
 rtl/div_seq.sv | 167 ++++++++++++++++
 tb/tb_div_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types for the sequential divider. Holds the FSM state
//                encoding and the encoding of the special-case results
//                (divide by zero, signed overflow) that skip the iteration.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_t;

  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_ZERO = 2'd1,
    SP_OVF  = 2'd2
  } div_special_t;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One restoring-division step (combinational). Shifts the next
//                dividend bit into the partial remainder, compares against the
//                divisor at WIDTH+1 bits and subtracts when it fits.
//  Ports       : rem      in  WIDTH  current partial remainder (< dvs)
//                dvd_bit  in  1      next dividend bit, MSB first
//                dvs      in  WIDTH  divisor magnitude
//                rem_next out WIDTH  partial remainder after this step
//                q_bit    out 1      quotient bit produced by this step
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  // The shifted remainder needs WIDTH+1 bits: with a divisor >= 2^(WIDTH-1)
  // the shifted value can exceed WIDTH bits before the subtraction.
  assign w_shift = {rem, dvd_bit};
  assign q_bit   = (w_shift >= {1'b0, dvs});

  // When the subtraction happens the true difference is below dvs, so it
  // fits in WIDTH bits and modular arithmetic on the low bits is exact.
  assign w_diff   = w_shift[WIDTH-1:0] - dvs;
  assign rem_next = q_bit ? w_diff : w_shift[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_seq
//  Description : Multicycle restoring divider (DIV/DIVU). Quotient to lo,
//                remainder to hi. One quotient bit per cycle on operand
//                magnitudes, sign fix-up in a final cycle. Divide-by-zero and
//                signed MIN/-1 bypass the iteration.
//  Ports       : clk       in  1      clock, all state on posedge
//                reset     in  1      asynchronous, active-low
//                start     in  1      request, sampled only when idle
//                is_signed in  1      1 = two's complement, 0 = unsigned
//                a         in  WIDTH  dividend
//                b         in  WIDTH  divisor
//                busy      out 1      operation in flight
//                done      out 1      one-cycle pulse, results valid
//                div_zero  out 1      last op divided by zero
//                overflow  out 1      last op was signed MIN/-1
//                hi        out WIDTH  remainder
//                lo        out WIDTH  quotient
//  Revision    : 1.0 - initial release
// ============================================================================
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [WIDTH-1:0] c_min      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH-1);

  div_state_t   r_state, w_next_state;
  div_special_t r_special;

  logic             r_neg_q, r_neg_r;
  logic [WIDTH-1:0] r_a, r_dvd, r_dvs, r_rem, r_quo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done, r_dz, r_ovf;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_b_zero, w_ovf_case;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_step_q;

  assign w_b_zero   = (b == '0);
  assign w_ovf_case = is_signed && (a == c_min) && (b == '1);
  assign w_a_mag    = (is_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign w_b_mag    = (is_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (r_rem),
    .dvd_bit  (r_dvd[r_cnt]),
    .dvs      (r_dvs),
    .rem_next (w_step_rem),
    .q_bit    (w_step_q)
  );

  // --------------------------------------------------------------------------
  // FSM: state register and next-state logic
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= DIV_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DIV_IDLE: if (start) w_next_state = (w_b_zero || w_ovf_case) ? DIV_FIX : DIV_RUN;
      DIV_RUN:  if (r_cnt == '0) w_next_state = DIV_FIX;
      DIV_FIX:  w_next_state = DIV_IDLE;
      default:  w_next_state = DIV_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_special <= SP_NONE;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_a       <= '0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_ovf     <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            r_dz    <= 1'b0;
            r_ovf   <= 1'b0;
            r_a     <= a;
            // Quotient sign follows sign(a)^sign(b); remainder follows a.
            r_neg_q <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r <= is_signed && a[WIDTH-1];
            r_dvd   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= c_cnt_init;
            if (w_b_zero)        r_special <= SP_ZERO;
            else if (w_ovf_case) r_special <= SP_OVF;
            else                 r_special <= SP_NONE;
          end
        end
        DIV_RUN: begin
          r_rem        <= w_step_rem;
          r_quo[r_cnt] <= w_step_q;
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        DIV_FIX: begin
          r_done <= 1'b1;
          case (r_special)
            SP_ZERO: begin
              r_lo <= '1;
              r_hi <= r_a;
              r_dz <= 1'b1;
            end
            SP_OVF: begin
              r_lo  <= r_a;
              r_hi  <= '0;
              r_ovf <= 1'b1;
            end
            default: begin
              r_lo <= r_neg_q ? (~r_quo + 1'b1) : r_quo;
              r_hi <= r_neg_r ? (~r_rem + 1'b1) : r_rem;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != DIV_IDLE);
  assign done     = r_done;
  assign div_zero = r_dz;
  assign overflow = r_ovf;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_seq
//  Description : Self-checking bench for div_seq. A 32-bit instance is checked
//                every cycle against an arithmetic reference model; an 8-bit
//                instance is checked with directed operations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start, is_signed;
  logic [31:0] a, b;
  logic        d_busy, d_done, d_dz, d_ovf;
  logic [31:0] d_hi, d_lo;

  logic        start8, s8;
  logic [7:0]  a8, b8;
  logic        d8_busy, d8_done, d8_dz, d8_ovf;
  logic [7:0]  d8_hi, d8_lo;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
    .a(a), .b(b), .busy(d_busy), .done(d_done), .div_zero(d_dz),
    .overflow(d_ovf), .hi(d_hi), .lo(d_lo)
  );

  div_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .is_signed(s8),
    .a(a8), .b(b8), .busy(d8_busy), .done(d8_done), .div_zero(d8_dz),
    .overflow(d8_ovf), .hi(d8_hi), .lo(d8_lo)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state for the 32-bit instance
  bit          pend = 1'b0;
  int          acc_cyc = -1, done_cyc = -1, last_done_cyc = -1;
  logic [31:0] p_lo, p_hi;
  bit          p_dz, p_ovf;
  logic [31:0] h_lo = '0, h_hi = '0;
  bit          h_dz = 1'b0, h_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain-arithmetic reference: truncating division on sign-extended values.
  function automatic void model(input int w, input bit sgn, input logic [31:0] av,
                                input logic [31:0] bv, output logic [31:0] lo_o,
                                output logic [31:0] hi_o, output bit dz_o,
                                output bit ovf_o, output int lat_o);
    longint sa, sb, q, r, mask;
    mask = (longint'(1) << w) - 1;
    sa = longint'(av);
    sb = longint'(bv);
    if (sgn && av[w-1]) sa = sa - (longint'(1) << w);
    if (sgn && bv[w-1]) sb = sb - (longint'(1) << w);
    dz_o = 1'b0; ovf_o = 1'b0; lat_o = w + 1; lo_o = '0; hi_o = '0;
    if (sb == 0) begin
      dz_o = 1'b1; lo_o = 32'(mask); hi_o = av; lat_o = 1;
    end else if (sgn && sa == -(longint'(1) << (w-1)) && sb == -1) begin
      ovf_o = 1'b1; lo_o = av; hi_o = '0; lat_o = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      lo_o = 32'(q & mask);
      hi_o = 32'(r & mask);
    end
  endfunction

  task automatic commit_if_due();
    if (pend && cyc >= done_cyc) begin
      h_lo = p_lo; h_hi = p_hi; h_dz = p_dz; h_ovf = p_ovf;
      last_done_cyc = done_cyc;
      pend = 1'b0;
    end
  endtask

  task automatic model_reset();
    pend = 1'b0; done_cyc = -1; last_done_cyc = -1;
    h_lo = '0; h_hi = '0; h_dz = 1'b0; h_ovf = 1'b0;
  endtask

  // Every-cycle compare of the 32-bit instance against the reference.
  always begin
    bit eb, ed;
    @(negedge clk);
    #2;
    commit_if_due();
    eb = pend && (cyc >= acc_cyc);
    ed = (cyc == last_done_cyc);
    chk("busy", d_busy, eb);
    chk("done", d_done, ed);
    chk("lo",   d_lo, h_lo);
    chk("hi",   d_hi, h_hi);
    chk("div_zero", d_dz,  eb ? 1'b0 : h_dz);
    chk("overflow", d_ovf, eb ? 1'b0 : h_ovf);
  end

  // Called between edges; returns just after the edge that would accept.
  task automatic start_op(input bit sgn, input logic [31:0] av, input logic [31:0] bv,
                          output bit accepted);
    int lat;
    commit_if_due();
    accepted = !pend;
    is_signed = sgn; a = av; b = bv; start = 1'b1;
    if (accepted) begin
      model(32, sgn, av, bv, p_lo, p_hi, p_dz, p_ovf, lat);
      acc_cyc  = cyc + 1;
      done_cyc = acc_cyc + lat;
      pend     = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_op32(input string tag, input bit sgn, input logic [31:0] av,
                          input logic [31:0] bv, output logic [31:0] lo_o,
                          output logic [31:0] hi_o, output bit dz_o, output bit ovf_o,
                          output int lat_o, output int busy_o);
    bit acc;
    start_op(sgn, av, bv, acc);
    chk({tag, "_accepted"}, acc, 1'b1);
    lat_o = -1; busy_o = 0; lo_o = '0; hi_o = '0; dz_o = 1'b0; ovf_o = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (d_done) begin
        lat_o = cyc - acc_cyc;
        lo_o = d_lo; hi_o = d_hi; dz_o = d_dz; ovf_o = d_ovf;
        break;
      end
      if (d_busy) busy_o++;
    end
    chk({tag, "_done_seen"}, lat_o >= 0, 1'b1);
  endtask

  task automatic run_op8(input bit sgn, input logic [7:0] av, input logic [7:0] bv,
                         output logic [7:0] lo_o, output logic [7:0] hi_o,
                         output bit ovf_o, output int lat_o);
    int acc8;
    s8 = sgn; a8 = av; b8 = bv; start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    acc8 = cyc;
    lat_o = -1; lo_o = '0; hi_o = '0; ovf_o = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (d8_done) begin
        lat_o = cyc - acc8; lo_o = d8_lo; hi_o = d8_hi; ovf_o = d8_ovf;
        break;
      end
    end
    chk("w8_done_seen", lat_o >= 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d expected finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] mlo, mhi, rlo, rhi;
    logic [7:0]  lo8, hi8;
    bit          mdz, movf, rdz, rovf, ovf8, acc;
    int          mlat, rlat, rbusy, lat8;

    start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    start8 = 1'b0; s8 = 1'b0; a8 = '0; b8 = '0;

    // Pin the reference model to hand-computed answers.
    model(32, 1'b1, 32'd100, 32'd7, mlo, mhi, mdz, movf, mlat);
    chk("model_100_7_lo", mlo, 32'd14);
    chk("model_100_7_hi", mhi, 32'd2);
    chk("model_100_7_lat", mlat, 32'd33);
    model(32, 1'b1, 32'hFFFFFF9C, 32'd7, mlo, mhi, mdz, movf, mlat);
    chk("model_m100_7_lo", mlo, 32'hFFFFFFF2);
    chk("model_m100_7_hi", mhi, 32'hFFFFFFFE);
    model(32, 1'b0, 32'hFFFFFFFF, 32'h80000001, mlo, mhi, mdz, movf, mlat);
    chk("model_u_big_lo", mlo, 32'd1);
    chk("model_u_big_hi", mhi, 32'h7FFFFFFE);
    model(8, 1'b1, 32'hF9, 32'h02, mlo, mhi, mdz, movf, mlat);
    chk("model_w8_lo", mlo, 32'hFD);
    chk("model_w8_hi", mhi, 32'hFF);

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Basic signed op: result, latency and busy length.
    run_op32("s100_7", 1'b1, 32'd100, 32'd7, rlo, rhi, rdz, rovf, rlat, rbusy);
    chk("s100_7_lo", rlo, 32'd14);
    chk("s100_7_hi", rhi, 32'd2);
    chk("s100_7_latency", rlat, 32'd33);
    chk("s100_7_busy_cycles", rbusy, 32'd33);

    // Sign combinations, issued back-to-back on the done cycle.
    run_op32("sm100_7", 1'b1, 32'hFFFFFF9C, 32'd7, rlo, rhi, rdz, rovf, rlat, rbusy);
    chk("sm100_7_lo", rlo, 32'hFFFFFFF2);
    chk("sm100_7_hi", rhi, 32'hFFFFFFFE);
    run_op32("s100_m7", 1'b1, 32'd100, 32'hFFFFFFF9, rlo, rhi, rdz, rovf, rlat, rbusy);
    chk("s100_m7_lo", rlo, 32'hFFFFFFF2);
    chk("s100_m7_hi", rhi, 32'd2);
    run_op32("sm7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, rlo, rhi, rdz, rovf, rlat, rbusy);
    chk("sm7_m2_lo", rlo, 32'd3);
    chk("sm7_m2_hi", rhi, 32'hFFFFFFFF);

    // Unsigned, including divisor with the MSB set.
    run_op32("u_max_2", 1'b0, 32'hFFFFFFFF, 32'd2, rlo, rhi, rdz, rovf, rlat, rbusy);
    chk("u_max_2_lo", rlo, 32'h7FFFFFFF);
    chk("u_max_2_hi", rhi, 32'd1);
    run_op32("u_max_big", 1'b0, 32'hFFFFFFFF, 32'h80000001, rlo, rhi, rdz, rovf, rlat, rbusy);
    chk("u_max_big_lo", rlo, 32'd1);
    chk("u_max_big_hi", rhi, 32'h7FFFFFFE);

    // Divide by zero, then a normal op clears the flag.
    run_op32("div0", 1'b0, 32'd5, 32'd0, rlo, rhi, rdz, rovf, rlat, rbusy);
    chk("div0_latency", rlat, 32'd1);
    chk("div0_flag", rdz, 1'b1);
    chk("div0_lo", rlo, 32'hFFFFFFFF);
    chk("div0_hi", rhi, 32'd5);
    run_op32("after_div0", 1'b0, 32'd9, 32'd4, rlo, rhi, rdz, rovf, rlat, rbusy);
    chk("after_div0_flag", rdz, 1'b0);
    chk("after_div0_lo", rlo, 32'd2);

    // Signed overflow, and the same operands unsigned.
    run_op32("ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, rlo, rhi, rdz, rovf, rlat, rbusy);
    chk("ovf_flag", rovf, 1'b1);
    chk("ovf_lo", rlo, 32'h80000000);
    chk("ovf_hi", rhi, 32'd0);
    chk("ovf_latency", rlat, 32'd1);
    run_op32("u_min_max", 1'b0, 32'h80000000, 32'hFFFFFFFF, rlo, rhi, rdz, rovf, rlat, rbusy);
    chk("u_min_max_flag", rovf, 1'b0);
    chk("u_min_max_lo", rlo, 32'd0);
    chk("u_min_max_hi", rhi, 32'h80000000);

    // Starts while busy are ignored; reset mid-operation aborts it.
    @(negedge clk);
    start_op(1'b1, 32'd1000, 32'd3, acc);
    repeat (3) @(negedge clk);
    start_op(1'b0, 32'd5, 32'd0, acc);
    @(negedge clk);
    start_op(1'b1, 32'd77, 32'd2, acc);
    for (int k = 0; k < 50 && cyc < acc_cyc + 10; k++) @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", d_busy, 1'b0);
    chk("rst_lo", d_lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    run_op32("s7_3", 1'b1, 32'd7, 32'd3, rlo, rhi, rdz, rovf, rlat, rbusy);
    chk("s7_3_lo", rlo, 32'd2);
    chk("s7_3_hi", rhi, 32'd1);

    // 8-bit instance.
    @(negedge clk);
    run_op8(1'b1, 8'hF9, 8'h02, lo8, hi8, ovf8, lat8);
    chk("w8_s_lo", lo8, 32'hFD);
    chk("w8_s_hi", hi8, 32'hFF);
    chk("w8_s_latency", lat8, 32'd9);
    run_op8(1'b0, 8'hF9, 8'h02, lo8, hi8, ovf8, lat8);
    chk("w8_u_lo", lo8, 32'h7C);
    chk("w8_u_hi", hi8, 32'h01);
    run_op8(1'b1, 8'h80, 8'hFF, lo8, hi8, ovf8, lat8);
    chk("w8_ovf_flag", ovf8, 1'b1);
    chk("w8_ovf_lo", lo8, 32'h80);
    chk("w8_ovf_latency", lat8, 32'd1);

    repeat (3) @(negedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
